// File: rtl/n_bit_csel_adder_pipeline.sv
// rtl/n_bit_csel_adder_pipeline.sv - pipelined carry-select adder/subtractor, one segment per stage
// Optional macro CSEL_ADDER_OVERFLOW_EN enables the registered signed-overflow output.
module n_bit_csel_adder_pipeline #(
  parameter int DATA_WID = 32,
  parameter int SEG_WID  = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                op,
  input  logic [DATA_WID-1:0] in1,
  input  logic [DATA_WID-1:0] in2,
  input  logic                carry_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_WID-1:0] sum,
  output logic                carry_out,
  output logic                overflow
);

  localparam int NUM_SEG = DATA_WID / SEG_WID;

  // Index 0 is the input register; index k+1 holds the output of segment stage k.
  logic [DATA_WID-1:0] a_q [0:NUM_SEG-1];
  logic [DATA_WID-1:0] a_d [0:NUM_SEG-1];
  logic [DATA_WID-1:0] b_q [0:NUM_SEG-1];
  logic [DATA_WID-1:0] b_d [0:NUM_SEG-1];
  logic [DATA_WID-1:0] s_q [0:NUM_SEG];
  logic [DATA_WID-1:0] s_d [0:NUM_SEG];
  logic                c_q [0:NUM_SEG];
  logic                c_d [0:NUM_SEG];
  logic                v_q [0:NUM_SEG];
  logic                v_d [0:NUM_SEG];
  logic                adv;

  // Reset term keeps in_ready high while reset_n is low regardless of stale out_valid.
  assign adv      = !v_q[NUM_SEG] || out_ready || !reset_n;
  assign in_ready = adv;

  always_comb begin
    logic [SEG_WID:0] r0;
    logic [SEG_WID:0] r1;
    logic [SEG_WID:0] sel;
    r0     = '0;
    r1     = '0;
    sel    = '0;
    a_d[0] = in1;
    b_d[0] = op ? ~in2 : in2;
    c_d[0] = op | carry_in;
    s_d[0] = '0;
    v_d[0] = in_valid;
    for (int k = 1; k < NUM_SEG; k++) begin
      a_d[k] = a_q[k-1];
      b_d[k] = b_q[k-1];
    end
    for (int k = 0; k < NUM_SEG; k++) begin
      r0  = {1'b0, a_q[k][k*SEG_WID +: SEG_WID]} + {1'b0, b_q[k][k*SEG_WID +: SEG_WID]};
      r1  = r0 + {{SEG_WID{1'b0}}, 1'b1};
      sel = c_q[k] ? r1 : r0;
      s_d[k+1] = s_q[k];
      s_d[k+1][k*SEG_WID +: SEG_WID] = sel[SEG_WID-1:0];
      c_d[k+1] = sel[SEG_WID];
      v_d[k+1] = v_q[k];
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      s_q <= '{default: '0};
      c_q <= '{default: 1'b0};
      v_q <= '{default: 1'b0};
    end else if (adv) begin
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      c_q <= c_d;
      v_q <= v_d;
    end
  end

  assign out_valid = v_q[NUM_SEG];
  assign sum       = s_q[NUM_SEG];
  assign carry_out = c_q[NUM_SEG];

`ifdef CSEL_ADDER_OVERFLOW_EN
  logic ov_q;
  logic ov_d;

  // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
  always_comb begin
    ov_d = a_q[NUM_SEG-1][DATA_WID-1] ^ b_q[NUM_SEG-1][DATA_WID-1]
         ^ s_d[NUM_SEG][DATA_WID-1] ^ c_d[NUM_SEG];
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ov_q <= 1'b0;
    end else if (adv) begin
      ov_q <= ov_d;
    end
  end

  assign overflow = ov_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_n_bit_csel_adder_pipeline.sv
// tb/tb_n_bit_csel_adder_pipeline.sv - directed scoreboard bench for n_bit_csel_adder_pipeline
module tb_n_bit_csel_adder_pipeline;

  logic        clock = 1'b0;
  logic        reset_n, in_valid, in_ready, op, carry_in;
  logic        out_valid, out_ready, carry_out, overflow;
  logic [31:0] in1, in2, sum;

  typedef struct packed {
    logic [31:0] s;
    logic        c;
    logic        v;
  } exp_t;

  exp_t sb[$];
  int   acc_cycs[$];
  int   out_cycs[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  int   lat, n;
  logic [31:0] held;

  n_bit_csel_adder_pipeline dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .in1(in1), .in2(in2), .carry_in(carry_in),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry_out(carry_out), .overflow(overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic o, input logic [31:0] a, input logic [31:0] b,
                                 input logic ci);
    exp_t        e;
    logic [31:0] bb;
    logic [32:0] ext;
    bb  = o ? ~b : b;
    ext = {1'b0, a} + {1'b0, bb} + {32'd0, (o ? 1'b1 : ci)};
    e.s = ext[31:0];
    e.c = ext[32];
`ifdef CSEL_ADDER_OVERFLOW_EN
    e.v = (a[31] == bb[31]) && (ext[31] != a[31]);
`else
    e.v = 1'b0;
`endif
    return e;
  endfunction

  // Transfers are sampled mid-cycle: they complete at the following posedge.
  always @(negedge clock) begin
    exp_t e;
    if (reset_n && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 64'd1, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("sum", {32'd0, sum}, {32'd0, e.s});
        chk("carry_out", {63'd0, carry_out}, {63'd0, e.c});
        chk("overflow", {63'd0, overflow}, {63'd0, e.v});
        out_cycs.push_back(cyc);
      end
    end
    if (reset_n && in_valid && in_ready) begin
      sb.push_back(model(op, in1, in2, carry_in));
      acc_cycs.push_back(cyc);
    end
  end

  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b, input logic ci);
    op = o; in1 = a; in2 = b; carry_in = ci; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(negedge clock);
      k++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 1'b0; op = 1'b0; in1 = '0; in2 = '0;
    carry_in = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_sum", {32'd0, sum}, 64'd0);
    chk("rst_carry", {63'd0, carry_out}, 64'd0);
    chk("rst_ovf", {63'd0, overflow}, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clock); #1;

    // Single add: latency and carry across a segment boundary.
    issue(1'b0, 32'h0000_00FF, 32'h0000_0001, 1'b0);
    lat = 1;
    @(negedge clock);
    while (!out_valid && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    chk("latency", 64'(lat), 64'd5);
    chk("sum_0x100", {32'd0, sum}, 64'h100);
    wait_drain("drain_basic");

    issue(1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    issue(1'b1, 32'h8000_0000, 32'h0000_0001, 1'b0);
    issue(1'b1, 32'h0000_0005, 32'h0000_0007, 1'b0);
    issue(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    issue(1'b0, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);
    wait_drain("drain_edges");

    // Back-to-back throughput.
    acc_cycs.delete();
    out_cycs.delete();
    for (int i = 0; i < 8; i++) issue(1'b0, 32'(i), 32'(i), 1'b0);
    wait_drain("drain_b2b");
    chk("b2b_count", 64'(out_cycs.size()), 64'd8);
    if (out_cycs.size() == 8 && acc_cycs.size() == 8) begin
      chk("b2b_consecutive", 64'(out_cycs[7] - out_cycs[0]), 64'd7);
      chk("b2b_latency", 64'(out_cycs[0] - acc_cycs[0]), 64'd5);
    end

    // Stall with results held at the output.
    out_ready = 1'b0;
    issue(1'b0, 32'h0000_0010, 32'h0000_0020, 1'b0);
    issue(1'b1, 32'h0000_0100, 32'h0000_0001, 1'b0);
    issue(1'b0, 32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("stall_out_valid", {63'd0, out_valid}, 64'd1);
    held = sum;
    for (int j = 0; j < 3; j++) begin
      @(posedge clock); #1;
      op = 1'b0; in1 = 32'(j + 100); in2 = 32'd1; carry_in = 1'b0; in_valid = 1'b1;
      @(negedge clock);
      chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
      chk("stall_valid_held", {63'd0, out_valid}, 64'd1);
      chk("stall_sum_held", {32'd0, sum}, {32'd0, held});
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("drain_stall");

    // Reset while operations are in flight.
    issue(1'b0, 32'd1, 32'd2, 1'b0);
    issue(1'b0, 32'd3, 32'd4, 1'b0);
    issue(1'b0, 32'd5, 32'd6, 1'b0);
    reset_n = 1'b0;
    in_valid = 1'b1; in1 = 32'hDEAD_BEEF; in2 = 32'd1;
    sb.delete();
    @(negedge clock);
    chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    in_valid = 1'b0;
    n = 0;
    for (int j = 0; j < 10; j++) begin
      @(negedge clock);
      if (out_valid !== 1'b0) n++;
    end
    chk("flush_no_output", 64'(n), 64'd0);
    @(posedge clock); #1;
    issue(1'b0, 32'h0000_0F0F, 32'h0000_F0F0, 1'b1);
    lat = 1;
    @(negedge clock);
    while (!out_valid && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    chk("post_rst_latency", 64'(lat), 64'd5);
    chk("post_rst_sum", {32'd0, sum}, 64'h0001_0000);
    wait_drain("drain_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
